// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-datapath signals for alu_issue_ctrl.
// slave = the issue controller; master = upstream decode, downstream consumer and the ALU.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_oper;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        alu_over;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_cout;
  logic        out_over;
  logic        out_illegal;
  logic        out_err;

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b,
    output in_ready,
    output alu_a, alu_b, alu_oper,
    input  alu_result, alu_zero, alu_cout, alu_over,
    output out_valid,
    input  out_ready,
    output out_result, out_zero, out_cout, out_over, out_illegal, out_err
  );

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b,
    input  in_ready,
    input  alu_a, alu_b, alu_oper,
    output alu_result, alu_zero, alu_cout, alu_over,
    input  out_valid,
    output out_ready,
    input  out_result, out_zero, out_cout, out_over, out_illegal, out_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: maps ALUOp/funct to a 3-bit ALU oper, drives registered operands, captures result after SETTLE_CYCLES.
// Latency: out_valid SETTLE_CYCLES edges after accept (same edge for illegal ops); one op per SETTLE_CYCLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready. Macro ALU_OVF_TRAP_EN enables the overflow trap.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  alu_issue_ctrl_if.slave io
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [2:0]  alu_oper_q;
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic        out_zero_q;
  logic        out_cout_q;
  logic        out_over_q;
  logic        out_illegal_q;

  logic [2:0]  dec_oper;
  logic        dec_legal;
  logic        accept;
  logic        capture;
  logic        ovf;
  logic [31:0] cap_result;

  always_comb begin
    dec_oper  = OP_ADD;
    dec_legal = 1'b1;
    case (io.in_aluop)
      2'b00: dec_oper = OP_ADD;
      2'b01: dec_oper = OP_SUB;
      2'b10: begin
        case (io.in_funct)
          6'h20:   dec_oper = OP_ADD;
          6'h22:   dec_oper = OP_SUB;
          6'h24:   dec_oper = OP_AND;
          6'h25:   dec_oper = OP_OR;
          6'h2A:   dec_oper = OP_SLT;
          6'h00:   dec_oper = OP_SLL;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept  = (state == S_IDLE) && io.in_valid;
  assign capture = (state == S_WAIT) && (cnt == 4'd0);

  // The ALU drives an overflow flag for every op; only add/sub give it meaning.
  assign ovf = ((alu_oper_q == OP_ADD) || (alu_oper_q == OP_SUB)) && io.alu_over;

`ifdef ALU_OVF_TRAP_EN
  logic out_err_q;

  assign cap_result = ovf ? 32'h0 : io.alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_err_q <= 1'b0;
    end else if (accept) begin
      out_err_q <= 1'b0;
    end else if (capture) begin
      out_err_q <= ovf;
    end
  end

  assign io.out_err = out_err_q;
`else
  assign cap_result = io.alu_result;
  assign io.out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      alu_a_q       <= 32'h0;
      alu_b_q       <= 32'h0;
      alu_oper_q    <= 3'b000;
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'h0;
      out_zero_q    <= 1'b0;
      out_cout_q    <= 1'b0;
      out_over_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            if (dec_legal) begin
              alu_a_q    <= io.in_a;
              alu_b_q    <= io.in_b;
              alu_oper_q <= dec_oper;
              cnt        <= CNT_INIT;
              state      <= S_WAIT;
            end else begin
              // Undecodable op completes at once without touching the ALU.
              out_result_q  <= 32'h0;
              out_zero_q    <= 1'b0;
              out_cout_q    <= 1'b0;
              out_over_q    <= 1'b0;
              out_illegal_q <= 1'b1;
              out_valid_q   <= 1'b1;
              state         <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            out_result_q  <= cap_result;
            out_zero_q    <= io.alu_zero;
            out_cout_q    <= io.alu_cout;
            out_over_q    <= ovf;
            out_illegal_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state         <= S_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready    = (state == S_IDLE);
  assign io.alu_a       = alu_a_q;
  assign io.alu_b       = alu_b_q;
  assign io.alu_oper    = alu_oper_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_result  = out_result_q;
  assign io.out_zero    = out_zero_q;
  assign io.out_cout    = out_cout_q;
  assign io.out_over    = out_over_q;
  assign io.out_illegal = out_illegal_q;

endmodule
